ghost_wall_sensor: RTL
======================

// Module: ghost_wall_sensor
// PURPOSE
//  Supplies the wall_up/down/left/right indicators that each ghost controller consumes.
//  Given a ghost tile (x,y), it looks up the four neighbour tiles in the 28x36 maze wall ROM.
//  One shared sensor serves all four ghosts via a valid/ready request and a registered
//  response; the ghost arbiter sits upstream.
// PARAMETERS
//  ROM_INIT     "maze_walls.mem"  $readmemb file, 1008 bits, bit addr = y*28+x, 1=wall
//  TUNNEL_ROW   17                row whose x=0/x=27 edges wrap (side tunnel)
//  DOOR_Y       15                ghost-house door row
//  DOOR_X0      13                first door column
//  DOOR_X1      14                last door column
// PORTS
//  clk         in   1  system clock (25 MHz)
//  reset_n     in   1  asynchronous, active-low reset
//  req_valid   in   1  request present
//  req_ready   out  1  sensor idle; request accepted on req_valid&req_ready edge
//  req_x       in   6  ghost tile X (0..27 legal)
//  req_y       in   6  ghost tile Y (0..35 legal)
//  door_open   in   1  1 = door tiles passable; sampled at acceptance
//  rsp_valid   out  1  one-cycle pulse: wall_* hold a fresh result
//  wall_up     out  1  tile (x,y-1) blocked
//  wall_down   out  1  tile (x,y+1) blocked
//  wall_left   out  1  tile (x-1,y) blocked
//  wall_right  out  1  tile (x+1,y) blocked
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, rsp_valid=0, wall_*=0, latched x/y=0.
//    req_ready=(state==IDLE), so it reads 1 out of reset.
//  - FSM: IDLE -> Q_UP -> Q_DN -> Q_LF -> Q_RT -> CAP -> IDLE.
//    IDLE leaves only on acceptance; all other states advance unconditionally.
//  - ROM is synchronous, 1-cycle read latency:
//    Q_UP issues UP addr; Q_DN issues DN and captures UP; Q_LF issues LF and captures DN;
//    Q_RT issues RT and captures LF; CAP captures RT.
//  - Latency is fixed: accept at edge 0, wall_* updated and rsp_valid=1 after edge 5.
//    rsp_valid lasts one cycle; req_ready is 1 in that same cycle (back-to-back, 1 req / 5 clk).
//  - wall_* hold their last result until the next CAP. They never change mid-sequence.
//  - Address = y*28+x, 10 bits, computed as (y<<4)+(y<<3)+(y<<2)+x. No multiplier.
//  - Off-grid neighbours keep the fixed timing; the ROM bit is ignored and a forced value used:
//    y=0 -> up=1;  y=35 -> down=1.
//    x=0: left=1, except on TUNNEL_ROW, where left reads tile (27,y).
//    x=27: right=1, except on TUNNEL_ROW, where right reads tile (0,y).
//  - Door override: a neighbour in row DOOR_Y, cols DOOR_X0..DOOR_X1 reports !door_open.
//    The ROM bit is ignored for it.
//  - Illegal request (x>27 or y>35): same 5-cycle sequence, all four wall_*=1.
//  - req_valid while busy is ignored (req_ready=0). Inputs are latched only at acceptance.
//  - Reset mid-sequence: immediate return to IDLE. No rsp_valid for the aborted request.
//    wall_* clear to 0.
// STRUCTURE
//  - maze_pkg holds: MAZE_W=28, MAZE_H=36, ROM_DEPTH=1008.
//    It also holds tile_addr(x,y), and the DIR_UP/DN/LF/RT encoding.
//    It is shared with pacman movement and the ghost controllers.
//  - Sub-module maze_wall_rom (1 read port, sync read, ROM_INIT) is instantiated once.
//    The FSM, neighbour/override logic and result registers stay in ghost_wall_sensor.
// TESTING
//  Use ROM test file: border walls set; (13,4)=1; tunnel row 17 open at x=0 and x=27.
//  1. Reset, req (13,5) valid 1 cycle -> rsp_valid exactly 5 clk after accept;
//     up=1, down=0, left=0, right=0.
//  2. req (0,17) then (27,17) back-to-back -> left/right follow tiles (27,17)/(0,17), not forced.
//     Second accept lands in the same cycle as the first rsp_valid.
//  3. req (0,5), (27,5), (5,0), (5,35) -> forced left=1, right=1, up=1, down=1 respectively.
//  4. req (13,16) with door_open=0 -> up=1; repeat with door_open=1 -> up=0.
//     door_open toggled mid-sequence has no effect.
//  5. req (30,40) -> all wall_*=1 after 5 clk. req_valid held during busy -> no extra rsp.
//  6. Drop reset_n during Q_LF -> outputs 0 asynchronously, no rsp_valid.
//     After release a new req completes normally.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg
//   Shared maze geometry for pacman movement, the ghost controllers and the
//   ghost wall sensor.
//   Contents:
//     MAZE_W, MAZE_H, ROM_DEPTH   maze size in tiles and wall ROM depth in bits
//     COORD_W, ADDR_W             tile coordinate and ROM address widths
//     LAST_COL, LAST_ROW          highest legal tile column / row
//     dir_e                       DIR_UP / DIR_DN / DIR_LF / DIR_RT neighbour encoding
//     tile_addr(x, y)             wall ROM bit address y*28+x, built from shifts only
package maze_pkg;

  localparam int MAZE_W    = 28;
  localparam int MAZE_H    = 36;
  localparam int ROM_DEPTH = MAZE_W * MAZE_H;  // 1008
  localparam int COORD_W   = 6;
  localparam int ADDR_W    = 10;

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(MAZE_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(MAZE_H - 1);

  typedef enum logic [1:0] {
    DIR_UP = 2'd0,
    DIR_DN = 2'd1,
    DIR_LF = 2'd2,
    DIR_RT = 2'd3
  } dir_e;

  // y*28 = y*16 + y*8 + y*4, so no multiplier is needed. Out-of-range
  // coordinates simply wrap; callers never use the ROM bit for those.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {{(ADDR_W-COORD_W){1'b0}}, y};
    xw = {{(ADDR_W-COORD_W){1'b0}}, x};
    return (yw << 4) + (yw << 3) + (yw << 2) + xw;
  endfunction

endpackage

// File: rtl/maze_wall_rom.sv
// maze_wall_rom
//   Single-port wall ROM of the 28x36 maze, one bit per tile (1 = wall).
//   Contents come from the ROM_BITS parameter (bit index = y*28+x).
//   Ports:
//     clk   in   system clock
//     addr  in   tile bit address
//     data  out  registered wall bit, valid one cycle after addr is presented
module maze_wall_rom
  import maze_pkg::*;
#(
  parameter logic [ROM_DEPTH-1:0] ROM_BITS = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic              data
);

  logic romMem [ROM_DEPTH];

  generate
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign romMem[gi] = ROM_BITS[gi];
    end
  endgenerate

  // Addresses past the last tile only occur for illegal requests, whose
  // result is forced anyway; read them as open floor.
  always_ff @(posedge clk) begin
    if (addr < ADDR_W'(ROM_DEPTH)) begin
      data <= romMem[addr];
    end else begin
      data <= 1'b0;
    end
  end

endmodule

// File: rtl/ghost_wall_sensor.sv
// ghost_wall_sensor
//   Shared wall sensor for the four ghost controllers. For an accepted ghost
//   tile (x,y) it looks up the four neighbour tiles in the wall ROM, one per
//   cycle, and presents all four results together with a one-cycle rsp_valid
//   exactly five clocks after acceptance.
//   Ports:
//     clk         in   system clock
//     reset_n     in   asynchronous active-low reset
//     req_valid   in   request present
//     req_ready   out  sensor idle; request accepted on req_valid & req_ready
//     req_x/req_y in   ghost tile coordinates (legal 0..27 / 0..35)
//     door_open   in   ghost-house door passable, sampled at acceptance
//     rsp_valid   out  one-cycle pulse, wall_* hold a fresh result
//     wall_up/down/left/right  out  neighbour blocked flags, held until next result
module ghost_wall_sensor
  import maze_pkg::*;
#(
  parameter logic [COORD_W-1:0]   TUNNEL_ROW = 6'd17,
  parameter logic [COORD_W-1:0]   DOOR_Y     = 6'd15,
  parameter logic [COORD_W-1:0]   DOOR_X0    = 6'd13,
  parameter logic [COORD_W-1:0]   DOOR_X1    = 6'd14,
  parameter logic [ROM_DEPTH-1:0] ROM_BITS   = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic               door_open,
  output logic               rsp_valid,
  output logic               wall_up,
  output logic               wall_down,
  output logic               wall_left,
  output logic               wall_right
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] Q_UP = 3'd1;
  localparam logic [2:0] Q_DN = 3'd2;
  localparam logic [2:0] Q_LF = 3'd3;
  localparam logic [2:0] Q_RT = 3'd4;
  localparam logic [2:0] CAP  = 3'd5;

  logic [2:0]         state;
  logic [COORD_W-1:0] xLat;
  logic [COORD_W-1:0] yLat;
  logic               doorLat;
  logic               illegalLat;

  dir_e               qDir;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic               forceHit;
  logic               forceVal;
  logic [ADDR_W-1:0]  romAddr;
  logic               romData;

  // Override decision travels alongside the ROM read so it lines up with romData.
  logic               forceHitQ;
  logic               forceValQ;
  logic               sensed;

  logic               upTmp;
  logic               dnTmp;
  logic               lfTmp;
  logic               accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (state)
      Q_DN:    qDir = DIR_DN;
      Q_LF:    qDir = DIR_LF;
      Q_RT:    qDir = DIR_RT;
      default: qDir = DIR_UP;
    endcase
  end

  // Neighbour coordinate for the direction being issued, plus whether the
  // ROM bit must be replaced (maze edge, ghost-house door, illegal request).
  always_comb begin
    nx       = xLat;
    ny       = yLat;
    forceHit = 1'b0;
    forceVal = 1'b0;
    case (qDir)
      DIR_UP: begin
        if (yLat == '0) begin
          forceHit = 1'b1;
          forceVal = 1'b1;
        end else begin
          ny = yLat - 1'b1;
        end
      end
      DIR_DN: begin
        if (yLat == LAST_ROW) begin
          forceHit = 1'b1;
          forceVal = 1'b1;
        end else begin
          ny = yLat + 1'b1;
        end
      end
      DIR_LF: begin
        if (xLat == '0) begin
          if (yLat == TUNNEL_ROW) begin
            nx = LAST_COL;
          end else begin
            forceHit = 1'b1;
            forceVal = 1'b1;
          end
        end else begin
          nx = xLat - 1'b1;
        end
      end
      DIR_RT: begin
        if (xLat == LAST_COL) begin
          if (yLat == TUNNEL_ROW) begin
            nx = '0;
          end else begin
            forceHit = 1'b1;
            forceVal = 1'b1;
          end
        end else begin
          nx = xLat + 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (!forceHit && (ny == DOOR_Y) && (nx >= DOOR_X0) && (nx <= DOOR_X1)) begin
      forceHit = 1'b1;
      forceVal = !doorLat;
    end
    if (illegalLat) begin
      forceHit = 1'b1;
      forceVal = 1'b1;
    end
  end

  assign romAddr = tile_addr(nx, ny);

  maze_wall_rom #(
    .ROM_BITS(ROM_BITS)
  ) wallRom (
    .clk (clk),
    .addr(romAddr),
    .data(romData)
  );

  assign sensed = forceHitQ ? forceValQ : romData;

  // Up/down/left results are parked in temporaries so that wall_* change
  // only once, together, when the last neighbour arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      xLat       <= '0;
      yLat       <= '0;
      doorLat    <= 1'b0;
      illegalLat <= 1'b0;
      forceHitQ  <= 1'b0;
      forceValQ  <= 1'b0;
      upTmp      <= 1'b0;
      dnTmp      <= 1'b0;
      lfTmp      <= 1'b0;
      rsp_valid  <= 1'b0;
      wall_up    <= 1'b0;
      wall_down  <= 1'b0;
      wall_left  <= 1'b0;
      wall_right <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      forceHitQ <= forceHit;
      forceValQ <= forceVal;
      case (state)
        IDLE: begin
          if (accept) begin
            xLat       <= req_x;
            yLat       <= req_y;
            doorLat    <= door_open;
            illegalLat <= (req_x > LAST_COL) || (req_y > LAST_ROW);
            state      <= Q_UP;
          end
        end
        Q_UP: state <= Q_DN;
        Q_DN: begin
          upTmp <= sensed;
          state <= Q_LF;
        end
        Q_LF: begin
          dnTmp <= sensed;
          state <= Q_RT;
        end
        Q_RT: begin
          lfTmp <= sensed;
          state <= CAP;
        end
        CAP: begin
          wall_up    <= upTmp;
          wall_down  <= dnTmp;
          wall_left  <= lfTmp;
          wall_right <= sensed;
          rsp_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
